// File: rtl/j_jbresp.sv
// Bus responder: runs one 32-bit or two 16-bit downstream beats per DSP master
// cycle and returns read data with a one-cycle ack. Optional timeout: JBRESP_TIMEOUT_EN.
module j_jbresp #(
    parameter int TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [23:0] addr,
    input  logic [31:0] wdata,
    input  logic        dsp16,
    input  logic        bigend,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        rw_reg;
    logic [23:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        dsp16_reg;
    logic        bigend_reg;
    logic [31:0] rdata_reg;
    logic        in_beat;
    logic        hi_half;
    logic        timeout_hit;
    logic        beat_entry;

    assign in_beat = (state_reg == BEAT0) || (state_reg == BEAT1);
    // Upper halfword travels first in big-endian order, second in little-endian.
    assign hi_half = (state_reg == BEAT0) ~^ bigend_reg;
    assign beat_entry = ((state_next == BEAT0) || (state_next == BEAT1)) && (state_next != state_reg);

`ifdef JBRESP_TIMEOUT_EN
    logic [9:0] wait_cnt_reg;
    logic       err_reg;
    logic       unused_bits;

    assign unused_bits = &{1'b0, addr[1:0]};
    // Abort on the cycle whose increment would make the count reach TIMEOUT.
    assign timeout_hit = in_beat && !mem_rdy && (wait_cnt_reg == 10'(TIMEOUT - 1));
    assign err = err_reg;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (beat_entry)
                wait_cnt_reg <= '0;
            else if (in_beat && !mem_rdy)
                wait_cnt_reg <= wait_cnt_reg + 10'd1;
            if (state_next == DONE && state_reg != DONE)
                err_reg <= timeout_hit;
        end
    end
`else
    logic unused_bits;

    assign unused_bits = &{1'b0, addr[1:0], 10'(TIMEOUT), beat_entry};
    assign timeout_hit = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (req) state_next = BEAT0;
            BEAT0: begin
                if (mem_rdy)
                    state_next = dsp16_reg ? BEAT1 : DONE;
                else if (timeout_hit)
                    state_next = DONE;
            end
            BEAT1: if (mem_rdy || timeout_hit) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            rw_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            dsp16_reg  <= 1'b0;
            bigend_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req) begin
                rw_reg     <= rw;
                addr_reg   <= {addr[23:2], 2'b00};
                wdata_reg  <= wdata;
                dsp16_reg  <= dsp16;
                bigend_reg <= bigend;
            end
            if (in_beat && mem_rdy && rw_reg) begin
                if (!dsp16_reg)
                    rdata_reg <= mem_rdata;
                else if (hi_half)
                    rdata_reg[31:16] <= mem_rdata[15:0];
                else
                    rdata_reg[15:0] <= mem_rdata[15:0];
            end else if (timeout_hit) begin
                rdata_reg <= 32'hFFFF_FFFF;
            end
        end
    end

    assign rdata = rdata_reg;

    always_comb begin
        ack       = (state_reg == DONE);
        mem_req   = in_beat;
        mem_we    = in_beat && !rw_reg;
        mem_addr  = '0;
        mem_wdata = '0;
        if (in_beat) begin
            mem_addr = (state_reg == BEAT1) ? addr_reg + 24'd2 : addr_reg;
            if (!dsp16_reg)
                mem_wdata = wdata_reg;
            else if (hi_half)
                mem_wdata = {16'h0000, wdata_reg[31:16]};
            else
                mem_wdata = {16'h0000, wdata_reg[15:0]};
        end
    end

endmodule
